rf_writeback_arbiter: RTL
=========================

// Module: rf_writeback_arbiter
// PURPOSE
//  Writer side of the 32x32 register file: merges writebacks from the single-cycle ALU and the
//  multi-cycle mult/div unit (MDU) onto the RF's one synchronous write port (RegWrite/wr_addr/wr_data).
//  ALU has strict priority; MDU results are buffered in a small FIFO until a free write slot.
//  Also keeps a pending-register scoreboard so the hazard unit can stall reads of MDU destinations.
// PARAMETERS
//  DATA_W      32  register data width
//  ADDR_W       5  register address width (NUM_REGS = 2**ADDR_W)
//  FIFO_DEPTH   2  MDU result FIFO entries; power of two, >= 2
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous, active-high reset
//  alu_we       in   1           ALU writeback request this cycle (never stalled)
//  alu_waddr    in   ADDR_W      ALU destination register
//  alu_wdata    in   DATA_W      ALU result
//  mdu_valid    in   1           MDU result valid
//  mdu_ready    out  1           FIFO can accept; = !full && !rst
//  mdu_waddr    in   ADDR_W      MDU destination register
//  mdu_wdata    in   DATA_W      MDU result
//  mark_valid   in   1           MDU op issued; set pending bit of mark_addr
//  mark_addr    in   ADDR_W      destination of issued MDU op
//  pending      out  2**ADDR_W   bit i = register i awaits MDU writeback (registered)
//  rf_we        out  1           to RF RegWrite (registered)
//  rf_waddr     out  ADDR_W      to RF wr_addr (registered)
//  rf_wdata     out  DATA_W      to RF wr_data (registered)
//  fifo_count   out  clog2(D)+1  MDU FIFO occupancy
//  err_waw      out  1           sticky: ALU wrote a register whose pending bit was set
// BEHAVIOUR
//  - Reset: rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, fifo_count=0, err_waw=0, FIFO flushed;
//    rst mid-operation discards FIFO contents and in-flight MDU handshake; no RF write issued.
//  - Latency: selected write appears on rf_* exactly 1 cycle after the request/pop cycle.
//  - Select per cycle: ALU if alu_we && alu_waddr!=0; else FIFO head if non-empty (pop); else rf_we=0.
//  - ALU with alu_waddr==0: dropped (rf_we=0), does not block the FIFO pop that cycle.
//  - MDU handshake: push when mdu_valid && mdu_ready; mdu_ready from registered count, so push
//    and pop in same cycle when full is impossible; push+pop same cycle when non-full: count unchanged.
//  - No fall-through: entry pushed in cycle t is eligible to pop at t+1 at the earliest.
//  - MDU result to addr 0: handshake accepted, not pushed, nothing written.
//  - Scoreboard: mark_valid && mark_addr!=0 sets pending[mark_addr]; pop of FIFO entry clears
//    pending[entry addr] in the pop cycle (visible next cycle, same cycle rf_we rises).
//    Same-cycle mark and clear of same addr: mark wins (bit stays 1). pending[0] always 0.
//  - err_waw set when ALU write selected and pending[alu_waddr]==1; cleared only by rst.
//  - Starvation: FIFO drains only on ALU-idle cycles; no fairness guarantee by design.
//  - Order: MDU results written in acceptance order; ALU may overtake buffered MDU results.
// STRUCTURE
//  - rf_pkg: REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, REG_ZERO=5'd0, typedef wb_req_t
//    {addr, data} shared with RF and hazard unit.
//  - Sub-module wb_fifo: synchronous FIFO (DEPTH, wb_req_t), push/pop/full/empty/count,
//    wrap-around pointers with extra MSB. Arbiter, scoreboard, output regs in top.
// TESTING
//  - Reset: hold rst 2 cycles mid-traffic with 2 FIFO entries -> all outputs 0, fifo_count=0, mdu_ready=0 during rst.
//  - ALU only: alu_we=1, addr=5, data=32'hDEADBEEF at t -> rf_we=1, rf_waddr=5, rf_wdata=DEADBEEF at t+1.
//  - Contention: ALU (3,32'h11) and MDU (7,32'h22) same cycle t -> t+1 writes r3; t+2 writes r7; pending[7] clears.
//  - Full: ALU busy 4 cycles, MDU pushes r8,r9 -> fifo_count=2, mdu_ready=0; ALU idle -> r8 then r9, ready returns.
//  - Scoreboard: mark r10 at t, then ALU writes r10 -> err_waw=1; mark and pop r10 same cycle -> pending[10]=1.
//  - Zero reg: alu_waddr=0 and mdu_waddr=0, mark_addr=0 -> rf_we=0, pending=0, FIFO unchanged.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Package    : rf_pkg
// Description: Register-file wide constants and the writeback request type
//              shared by the RF, the hazard unit and the writeback arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One register writeback: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module     : wb_fifo
// Description: Synchronous FIFO of writeback requests. Pointers carry one
//              extra MSB so full/empty fall out of a plain subtraction.
//              The head is only visible once the write has been registered,
//              so an entry can never be pushed and popped in one cycle.
// Revision   : 1.0 - initial release
// ============================================================================
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_DEPTH = (PTR_W + 1)'(DEPTH);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign count     = r_wptr - r_rptr;
  assign full      = (count == c_DEPTH);
  assign empty     = (count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rptr[PTR_W-1:0]];

  // Pointer update; reset flushes the queue by realigning both pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[PTR_W-1:0]] <= push_data;
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : rf_writeback_arbiter
// Description: Merges ALU and MDU writebacks onto the single RF write port.
//              ALU has strict priority; MDU results wait in a small FIFO and
//              drain on ALU-idle cycles. A pending-register scoreboard tracks
//              issued MDU destinations for the hazard unit.
// Revision   : 1.0 - initial release
// ============================================================================
module rf_writeback_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_we,
  input  logic [ADDR_W-1:0]           alu_waddr,
  input  logic [DATA_W-1:0]           alu_wdata,
  input  logic                        mdu_valid,
  output logic                        mdu_ready,
  input  logic [ADDR_W-1:0]           mdu_waddr,
  input  logic [DATA_W-1:0]           mdu_wdata,
  input  logic                        mark_valid,
  input  logic [ADDR_W-1:0]           mark_addr,
  output logic [(2**ADDR_W)-1:0]      pending,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err_waw
);

  localparam int c_NUM_REGS = 2 ** ADDR_W;

  logic                   w_alu_sel;
  logic                   w_mdu_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  wb_req_t                w_push_req;
  wb_req_t                w_head;
  logic [c_NUM_REGS-1:0]  w_pending_nxt;

  logic                   r_rf_we;
  logic [ADDR_W-1:0]      r_rf_waddr;
  logic [DATA_W-1:0]      r_rf_wdata;
  logic [c_NUM_REGS-1:0]  r_pending;
  logic                   r_err_waw;

  // Writes to r0 are architecturally void: drop them at the source.
  assign w_alu_sel    = alu_we && (alu_waddr != REG_ZERO);
  assign mdu_ready    = !w_full && !rst;
  assign w_mdu_accept = mdu_valid && mdu_ready;
  assign w_push       = w_mdu_accept && (mdu_waddr != REG_ZERO);
  assign w_pop        = !w_alu_sel && !w_empty;

  assign w_push_req.addr = mdu_waddr;
  assign w_push_req.data = mdu_wdata;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_req),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (fifo_count)
  );

  // Register the selected write: ALU first, otherwise the FIFO head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_alu_sel) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= alu_waddr;
      r_rf_wdata <= alu_wdata;
    end else if (w_pop) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= w_head.addr;
      r_rf_wdata <= w_head.data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  // Next scoreboard: pop clears, a new issue to the same register wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) w_pending_nxt[w_head.addr] = 1'b0;
    if (mark_valid && (mark_addr != REG_ZERO)) w_pending_nxt[mark_addr] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= w_pending_nxt;
  end

  // Sticky WAW flag: ALU overwrote a register an MDU op still owns.
  always_ff @(posedge clk) begin
    if (rst)                                 r_err_waw <= 1'b0;
    else if (w_alu_sel && r_pending[alu_waddr]) r_err_waw <= 1'b1;
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign pending  = r_pending;
  assign err_waw  = r_err_waw;

endmodule : rf_writeback_arbiter
`default_nettype wire
